// File: rtl/i2c_bus_arbiter_if.sv
// rtl/i2c_bus_arbiter_if.sv - requester and driver-side signal bundle for i2c_bus_arbiter
interface i2c_bus_arbiter_if #(
  parameter int MAX_BYTES = 6
);
  localparam int NBW = $clog2(MAX_BYTES) + 1;
  localparam int DW  = 8 * MAX_BYTES;

  // requester side
  logic [1:0]     req;
  logic [1:0]     wr;
  logic [6:0]     dev0;
  logic [6:0]     dev1;
  logic [7:0]     addr0;
  logic [7:0]     addr1;
  logic [NBW-1:0] nbytes0;
  logic [NBW-1:0] nbytes1;
  logic [DW-1:0]  wdata0;
  logic [DW-1:0]  wdata1;
  logic [1:0]     ack;
  logic           err;
  logic [DW-1:0]  rdata;

  // low-level driver side
  logic           drv_disable;
  logic           drv_start;
  logic           drv_write;
  logic [6:0]     drv_dev;
  logic [7:0]     drv_addr;
  logic [NBW-1:0] drv_nbytes;
  logic [DW-1:0]  drv_wdata;
  logic           drv_done;
  logic [DW-1:0]  drv_rdata;

  // environment view: requesters plus the driver it controls
  modport master (
    output req, wr, dev0, dev1, addr0, addr1, nbytes0, nbytes1, wdata0, wdata1,
    output drv_done, drv_rdata,
    input  ack, err, rdata,
    input  drv_disable, drv_start, drv_write, drv_dev, drv_addr, drv_nbytes, drv_wdata
  );

  // arbiter view
  modport slave (
    input  req, wr, dev0, dev1, addr0, addr1, nbytes0, nbytes1, wdata0, wdata1,
    input  drv_done, drv_rdata,
    output ack, err, rdata,
    output drv_disable, drv_start, drv_write, drv_dev, drv_addr, drv_nbytes, drv_wdata
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - two-port round-robin arbiter in front of a low-level I2C driver
module i2c_bus_arbiter #(
  parameter int MAX_BYTES      = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic              i2c_clock,
  input logic              rst,
  i2c_bus_arbiter_if.slave bus
);
  localparam int NBW = $clog2(MAX_BYTES) + 1;
  localparam int DW  = 8 * MAX_BYTES;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [NBW-1:0] MAX_NB       = NBW'(MAX_BYTES);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // granted port and round-robin history; last_served=1 makes port 0 win the first tie
  logic g;
  logic last_served;

  // latched command presented to the driver
  logic           cmd_write;
  logic [6:0]     cmd_dev;
  logic [7:0]     cmd_addr;
  logic [NBW-1:0] cmd_nbytes;
  logic [DW-1:0]  cmd_wdata;

  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic [TW-1:0] tcount;

  // candidate winner and its request fields
  logic           winner;
  logic           win_write;
  logic [6:0]     win_dev;
  logic [7:0]     win_addr;
  logic [NBW-1:0] win_nbytes;
  logic [DW-1:0]  win_wdata;

  logic grant;
  logic reject;
  logic done_hit;
  logic timeout_hit;

  logic [1:0] ack_c;
  logic       err_c;
  logic       start_c;
  logic       disable_c;

  // round-robin pick: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    winner = bus.req[1];
    if (bus.req == 2'b11) begin
      winner = ~last_served;
    end
    win_write  = winner ? bus.wr[1]   : bus.wr[0];
    win_dev    = winner ? bus.dev1    : bus.dev0;
    win_addr   = winner ? bus.addr1   : bus.addr0;
    win_nbytes = winner ? bus.nbytes1 : bus.nbytes0;
    win_wdata  = winner ? bus.wdata1  : bus.wdata0;
  end

  assign grant       = (state == ST_IDLE) && (bus.req != 2'b00);
  assign reject      = (win_nbytes > MAX_NB);
  assign done_hit    = (state == ST_WAIT) && bus.drv_done;
  assign timeout_hit = (state == ST_WAIT) && (tcount == TIMEOUT_LAST);

  // state register
  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state: oversize requests skip the driver entirely; done beats timeout
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nx = reject ? ST_RESP : ST_START;
        end
      end
      ST_START: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (done_hit || timeout_hit) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // outputs decoded from state; driver runs only in START and WAIT
  always_comb begin
    ack_c     = 2'b00;
    err_c     = 1'b0;
    start_c   = 1'b0;
    disable_c = 1'b1;
    case (state)
      ST_START: begin
        start_c   = 1'b1;
        disable_c = 1'b0;
      end
      ST_WAIT: begin
        disable_c = 1'b0;
      end
      ST_RESP: begin
        ack_c = g ? 2'b10 : 2'b01;
        err_c = err_q;
      end
      default: begin
        ack_c = 2'b00;
      end
    endcase
  end

  // latch winner's command and update round-robin history on every grant
  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) begin
      g           <= 1'b0;
      last_served <= 1'b1;
      cmd_write   <= 1'b0;
      cmd_dev     <= '0;
      cmd_addr    <= '0;
      cmd_nbytes  <= '0;
      cmd_wdata   <= '0;
    end else if (grant) begin
      g           <= winner;
      last_served <= winner;
      cmd_write   <= win_write;
      cmd_dev     <= win_dev;
      cmd_addr    <= win_addr;
      cmd_nbytes  <= win_nbytes;
      cmd_wdata   <= win_wdata;
    end
  end

  // timeout counter: zero on entry to WAIT, counts every WAIT cycle
  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) begin
      tcount <= '0;
    end else if (state == ST_START) begin
      tcount <= '0;
    end else if (state == ST_WAIT) begin
      tcount <= tcount + 1'b1;
    end
  end

  // completion status and read data capture
  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        err_q <= reject;
      end else if (done_hit) begin
        err_q <= 1'b0;
        if (!cmd_write) begin
          rdata_q <= bus.drv_rdata;
        end
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.ack         = ack_c;
  assign bus.err         = err_c;
  assign bus.rdata       = rdata_q;
  assign bus.drv_disable = disable_c;
  assign bus.drv_start   = start_c;
  assign bus.drv_write   = cmd_write;
  assign bus.drv_dev     = cmd_dev;
  assign bus.drv_addr    = cmd_addr;
  assign bus.drv_nbytes  = cmd_nbytes;
  assign bus.drv_wdata   = cmd_wdata;
endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter MAX_BYTES, default 6: maximum bytes per transaction; sets data bus width 8*MAX_BYTES.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: i2c_clock cycles allowed in WAIT before abort.
REQ-003 Reset rst is asynchronous and active-high, and the clock is i2c_clock.
REQ-004 i2c_clock  in  1  I2C-rate system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req  in  2  per-port transaction request; held high until that port's ack.
REQ-007 wr  in  2  per-port direction: 1 = write, 0 = read.
REQ-008 dev0, dev1  in  7 each  per-port 7-bit target device address.
REQ-009 addr0, addr1  in  8 each  per-port register address.
REQ-010 nbytes0, nbytes1  in  $clog2(MAX_BYTES)+1 each  per-port byte count.
REQ-011 wdata0, wdata1  in  8*MAX_BYTES each  per-port write data; byte k at bits [8k+7:8k].
REQ-012 ack  out  2  one-cycle per-port completion strobe.
REQ-013 err  out  1  valid with ack; 1 = timeout or illegal length.
REQ-014 rdata  out  8*MAX_BYTES  read data of the last successful read.
REQ-015 drv_disable  out  1  holds the low-level I2C driver idle when high.
REQ-016 drv_start  out  1  one-cycle start pulse to the driver (its communicate input).
REQ-017 drv_write, drv_dev, drv_addr, drv_nbytes, drv_wdata  out  1/7/8/nbytes width/8*MAX_BYTES  latched command to the driver.
REQ-018 drv_done  in  1  driver completion flag.
REQ-019 drv_rdata  in  8*MAX_BYTES  driver read data.

Function
REQ-020 FSM states: IDLE, START, WAIT, RESP; encoding is free.
REQ-021 IDLE: drv_disable=1 and drv_start=0; at an edge with any req bit high, pick a winner, latch its wr/dev/addr/nbytes/wdata into the drv_* registers, store the winner index g, and go to START.
REQ-022 Arbitration is round-robin. A single requester wins. With both ports requesting, the port not served last wins. A last_served bit updates on every grant.
REQ-023 If the winner's nbytes is greater than MAX_BYTES, the transaction is rejected: go to RESP with err=1, issue no drv_start, and leave drv_disable at 1.
REQ-024 START lasts exactly one cycle: drv_disable=0, drv_start=1, then go to WAIT.
REQ-025 WAIT: drv_disable=0 and drv_start=0. The timeout counter clears on entry and increments each cycle.
REQ-026 In WAIT, drv_done=1 sampled at an edge → go to RESP with err=0. If wr=0 for the granted port, load rdata from drv_rdata at that edge; if wr=1, rdata is unchanged.
REQ-027 In WAIT, counter = TIMEOUT_CYCLES-1 with no drv_done → go to RESP with err=1 and rdata unchanged. If drv_done and timeout occur on the same edge, done wins.
REQ-028 RESP lasts exactly one cycle: ack[g]=1, err valid, drv_disable=1; then go to IDLE unconditionally.
REQ-029 drv_done is ignored in every state except WAIT.
REQ-030 Deasserting req mid-transaction does not abort the transaction; its ack still pulses.
REQ-031 drv_* command registers hold stable from START through RESP.
REQ-032 Latency: req sampled at edge N → drv_start high in cycle N+1. drv_done sampled at edge M → ack high in cycle M+1. Minimum one IDLE cycle between transactions.
REQ-033 Zero-length write (nbytes=0, pointer set) is legal and proceeds normally.
REQ-034 ack bits are never both high; ack and drv_start are never high together.

Reset
REQ-035 When rst is asserted, asynchronously force: state IDLE, ack=0, err=0, rdata=0, drv_start=0, drv_disable=1, drv_* command registers 0, timeout counter 0, last_served=1 (port 0 wins the first tie).
REQ-036 Reset mid-transaction aborts with no ack. After release, the first sampled req is arbitrated fresh.

Verification
REQ-037 Port 0 read, dev=0x52, addr=0x00, nbytes=6; driver returns drv_done after 40 cycles with data 0x0102030405AA → drv_start pulses once, ack[0] for 1 cycle, err=0, rdata=0x0102030405AA.
REQ-038 Both req bits high from reset and held → grants alternate 0,1,0,1; each drv_start is preceded by exactly one IDLE cycle.
REQ-039 Port 1 write, nbytes=1, wdata=0x55, and drv_done never asserts → ack[1] with err=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; rdata unchanged.
REQ-040 Port 0 request with nbytes=7 → ack[0] with err=1 two cycles later; drv_start stays 0 and drv_disable stays 1 throughout.
REQ-041 rst pulsed during WAIT → drv_disable=1 immediately, no ack; after release, a port-1-only request completes normally.
REQ-042 Spurious drv_done while in IDLE, then in RESP → no state change and no ack.
